ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 121 ++++++++++++
 tb/tb_ifetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module      : ifetch_unit
// Description : Sequential instruction fetch with a 2-entry {pc, inst} FIFO,
//               redirect handling and misalignment / range fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [1:0]  fault
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FAULT = 2'd2;

    localparam logic [1:0] c_FAULT_NONE     = 2'b00;
    localparam logic [1:0] c_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] c_FAULT_RANGE    = 2'b10;

    localparam logic [30:0] c_IMEM_WORDS = 31'(IMEM_WORDS);

    logic [1:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_fault;
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_inst [2];

    logic        w_pop;
    logic        w_in_range;
    logic        w_push;

    assign imem_pc   = r_fetch_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_pc    = r_buf_pc[r_rd_ptr];
    assign out_inst  = r_buf_inst[r_rd_ptr];
    assign fault     = r_fault;

    assign w_pop      = out_valid & out_ready;
    assign w_in_range = ({1'b0, r_fetch_pc[31:2]} < c_IMEM_WORDS);
    // A full FIFO can still accept a fetch when the head leaves in the same cycle.
    assign w_push     = !redirect_valid && (r_state == c_RUN) && w_in_range
                        && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_count       <= 2'd0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_fault       <= c_FAULT_NONE;
            r_buf_pc[0]   <= 32'h0;
            r_buf_pc[1]   <= 32'h0;
            r_buf_inst[0] <= 32'h0;
            r_buf_inst[1] <= 32'h0;
        end else if (redirect_valid) begin
            // Redirect flushes everything, including a pop offered this cycle.
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fetch_pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                r_state <= c_FAULT;
                r_fault <= c_FAULT_MISALIGN;
            end else begin
                r_state <= c_RUN;
                r_fault <= c_FAULT_NONE;
            end
        end else begin
            case (r_state)
                c_IDLE:  r_state <= c_RUN;
                c_RUN: begin
                    if (!w_in_range) begin
                        r_state <= c_FAULT;
                        r_fault <= c_FAULT_RANGE;
                    end
                end
                c_FAULT: r_state <= c_FAULT;
                default: r_state <= c_IDLE;
            endcase

            if (w_push) begin
                r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
                r_buf_inst[r_wr_ptr] <= imem_inst;
                r_wr_ptr             <= ~r_wr_ptr;
                r_fetch_pc           <= r_fetch_pc + 32'd4;
            end

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed table-driven bench for ifetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  fault;

    int n_total;
    int n_pass;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eimem;
        logic [1:0]  ef;
    } vec_t;

    vec_t vecs [0:15];

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    // Instruction memory model: each word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {~pc[15:0], pc[15:0]};
    endfunction

    assign imem_inst = mem_word(imem_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc(input string tag, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eimem,
                       input logic [1:0] ef);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, ev});
        chk({tag, ".imem_pc"}, imem_pc, eimem);
        chk({tag, ".fault"}, {30'h0, fault}, {30'h0, ef});
        if (ev) begin
            chk({tag, ".out_pc"}, out_pc, epc);
            chk({tag, ".out_inst"}, out_inst, mem_word(epc));
        end
    endtask

    initial begin
        n_total        = 0;
        n_pass         = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        //            rv    rpc           rdy   ev    epc           eimem         ef
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h00,       2'b00}; // IDLE
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h00,       32'h04,       2'b00};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h00,       32'h08,       2'b00};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h00,       32'h08,       2'b00}; // full
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h04,       32'h0C,       2'b00};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h08,       32'h10,       2'b00};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h08,       32'h10,       2'b00};
        vecs[7]  = '{1'b1, 32'h0C,       1'b1, 1'b0, 32'h00,       32'h0C,       2'b00}; // flush
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0C,       32'h10,       2'b00};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'h14,       2'b00};
        vecs[10] = '{1'b1, 32'h06,       1'b1, 1'b0, 32'h00,       32'h06,       2'b01}; // misaligned
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h00,       32'h06,       2'b01};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h00,       32'h06,       2'b01};
        vecs[13] = '{1'b1, 32'h10,       1'b1, 1'b0, 32'h00,       32'h10,       2'b00};
        vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'h14,       2'b00};
        vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h14,       32'h18,       2'b00};

        #2;
        chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst.imem_pc", imem_pc, 32'h0);
        chk("rst.fault", {30'h0, fault}, 32'h0);
        chk("rst.out_pc", out_pc, 32'h0);
        chk("rst.out_inst", out_inst, 32'h0);
        #20;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rpc, vecs[i].rdy,
                vecs[i].ev, vecs[i].epc, vecs[i].eimem, vecs[i].ef);
        end

        // Free-run to the end of memory: last entry 0x7C, then range fault at 0x80.
        cyc("end0", 1'b1, 32'h70, 1'b1, 1'b0, 32'h00, 32'h70, 2'b00);
        cyc("end1", 1'b0, 32'h00, 1'b1, 1'b1, 32'h70, 32'h74, 2'b00);
        cyc("end2", 1'b0, 32'h00, 1'b1, 1'b1, 32'h74, 32'h78, 2'b00);
        cyc("end3", 1'b0, 32'h00, 1'b1, 1'b1, 32'h78, 32'h7C, 2'b00);
        cyc("end4", 1'b0, 32'h00, 1'b1, 1'b1, 32'h7C, 32'h80, 2'b00);
        cyc("end5", 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h80, 2'b10);
        cyc("end6", 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h80, 2'b10);

        // Range fault with entries still buffered: they must drain afterwards.
        cyc("drn0", 1'b1, 32'h78, 1'b0, 1'b0, 32'h00, 32'h78, 2'b00);
        cyc("drn1", 1'b0, 32'h00, 1'b0, 1'b1, 32'h78, 32'h7C, 2'b00);
        cyc("drn2", 1'b0, 32'h00, 1'b0, 1'b1, 32'h78, 32'h80, 2'b00);
        cyc("drn3", 1'b0, 32'h00, 1'b0, 1'b1, 32'h78, 32'h80, 2'b10);
        cyc("drn4", 1'b0, 32'h00, 1'b1, 1'b1, 32'h7C, 32'h80, 2'b10);
        cyc("drn5", 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h80, 2'b10);

        // Fill to two entries, then assert reset asynchronously mid-cycle.
        cyc("mrs0", 1'b1, 32'h20, 1'b0, 1'b0, 32'h00, 32'h20, 2'b00);
        cyc("mrs1", 1'b0, 32'h00, 1'b0, 1'b1, 32'h20, 32'h24, 2'b00);
        cyc("mrs2", 1'b0, 32'h00, 1'b0, 1'b1, 32'h20, 32'h28, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrs.out_valid", {31'h0, out_valid}, 32'h0);
        chk("mrs.imem_pc", imem_pc, 32'h0);
        chk("mrs.out_pc", out_pc, 32'h0);
        chk("mrs.out_inst", out_inst, 32'h0);
        chk("mrs.fault", {30'h0, fault}, 32'h0);
        #2;
        rst_n = 1'b1;

        cyc("rst0", 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 32'h00, 2'b00);
        cyc("rst1", 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 32'h04, 2'b00);
        cyc("rst2", 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 32'h08, 2'b00);
        cyc("rst3", 1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 32'h0C, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
